note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Sequences the single-note tone generator. Holds a small programmable
//  melody table of {note, duration} entries and plays it back, producing the
//  3-bit note code the tone generator consumes (0 = silent, 1..7 = A..G).
//  A live key input always takes priority over playback, so the keyboard
//  and the sequencer share one tone generator.
// PARAMETERS
//  DEPTH     16     melody table entries; power of 2; AW = log2(DEPTH)
//  DUR_W     8      duration field width, in ticks
//  TICK_DIV  50000  clk cycles per tick (1 ms at 50 MHz)
//  GAP_TICKS 20     silent ticks between consecutive entries; 0 = no gap
// PORTS
//  clk        in   1      system clock, 50 MHz
//  resetn     in   1      asynchronous, active-low reset
//  wr_en      in   1      write table entry at wr_addr this cycle
//  wr_addr    in   AW     table address
//  wr_note    in   3      note code to store (0 = rest)
//  wr_dur     in   DUR_W  duration in ticks to store
//  length     in   AW+1   entries to play; sampled on accepted start
//  loop       in   1      wrap to entry 0 after last entry (live level)
//  start      in   1      one-cycle pulse: begin playback at entry 0
//  stop       in   1      one-cycle pulse: abort playback
//  key_note   in   3      live keyboard note; nonzero overrides playback
//  note       out  3      registered note code to the tone generator
//  busy       out  1      high in PLAY or GAP
//  step_idx   out  AW     index of the entry currently playing
//  done       out  1      one-cycle pulse when a non-looping run completes
// BEHAVIOUR
//  - Reset: state IDLE; note=0, busy=0, step_idx=0, done=0; prescaler and
//    duration counter 0; table contents undefined (not reset).
//  - Tick: prescaler counts 0..TICK_DIV-1 while busy; tick pulses when it
//    equals TICK_DIV-1. Prescaler is cleared on every entry load and gap load,
//    so each note and each gap lasts exactly dur*TICK_DIV cycles.
//  - States: IDLE, PLAY, GAP.
//    IDLE -> PLAY on start & !stop & len>0: len_q = min(length, DEPTH),
//      idx=0, cnt=max(dur[0],1). If len==0: done pulses next cycle, stay IDLE.
//    PLAY: decrement cnt on tick; at tick with cnt==1 -> GAP with
//      cnt=GAP_TICKS, or directly to the next-entry decision if GAP_TICKS==0.
//    GAP: same countdown; at expiry decide next entry:
//      idx<len_q-1 -> PLAY, idx+1; else loop=1 -> PLAY, idx=0;
//      else -> IDLE with a done pulse.
//  - Duration 0 is played as 1 tick. Note 0 is a rest: silent, still timed.
//  - Latency: note output is registered; the first note appears 1 cycle
//    after start; note goes to 0 in the same cycle GAP is entered.
//  - Output mux (registered): note = key_note!=0 ? key_note
//    : (state==PLAY ? entry note : 0). key_note never pauses or alters timing.
//  - stop: any state -> IDLE next cycle; note follows key_note only; no done.
//    stop and start in the same cycle: stop wins.
//  - start while busy: restarts from entry 0 with length resampled.
//  - Writes are accepted in every state. An entry's note/duration is fetched
//    once, when that entry is loaded; a write to an entry already playing
//    takes effect on its next play. Write and load of the same address in
//    the same cycle: the old value is loaded.
//  - length > DEPTH is clamped to DEPTH. Changes to loop mid-run affect only
//    the end-of-table decision.
// TESTING (TICK_DIV=4, GAP_TICKS=1, DEPTH=16)
//  1. Reset mid-play (resetn low 1 cycle during PLAY) -> note=0, busy=0,
//     done=0 immediately; no activity until the next start.
//  2. Load {A,2},{C,3}, length=2, loop=0, start -> note=1 for 8 cycles,
//     0 for 4, 3 for 12, 0 for 4; then done pulses 1 cycle, busy=0.
//  3. Same table with loop=1 -> sequence repeats; step_idx goes 0,1,0,1;
//     no done. Clear loop during entry 1 -> one final pass ends with done.
//  4. key_note=5 held during entry 0 -> note=5; release -> note=1; total
//     entry-0 duration still 8 cycles.
//  5. start with length=0 -> done pulse next cycle, busy stays 0.
//     stop during PLAY -> note=0 next cycle, no done.
//  6. Entry {G,0} -> note=7 for exactly 4 cycles; length=20 -> 16 entries
//     play, step_idx wraps 15->done.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: plays a programmable {note, duration} melody table into a
// single tone generator; a nonzero live key note always overrides playback.
module note_sequencer #(
   parameter int  DEPTH     = 16,
   parameter int  DUR_W     = 8,
   parameter int  TICK_DIV  = 50000,
   parameter int  GAP_TICKS = 20,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [2:0]       wr_note_i,
   input  logic [DUR_W-1:0] wr_dur_i,
   input  logic [AW:0]      length_i,
   input  logic             loop_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [2:0]       key_note_i,
   output logic [2:0]       note_o,
   output logic             busy_o,
   output logic [AW-1:0]    step_idx_o,
   output logic             done_o,
   output logic [1:0]       state_o
);
   localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
   localparam int GW = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
   localparam int CW = (DUR_W > GW) ? DUR_W : GW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [AW:0]     len_q, len_d;
   logic [2:0]      cur_note_q, cur_note_d;
   logic [2:0]      note_q, note_d;
   logic            done_q, done_d;

   logic [2+DUR_W:0] tbl [DEPTH];
   logic [2+DUR_W:0] ld_entry;
   logic [DUR_W-1:0] ld_dur;
   logic [AW-1:0]    ld_addr;
   logic             load, finish, advance, to_gap, expire, tick, last;

   // Table is storage only; it is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) tbl[wr_addr_i] <= {wr_note_i, wr_dur_i};
   end

   // The load reads before this cycle's write lands, so a same-cycle
   // write/load of one address fetches the old entry.
   assign ld_entry = tbl[ld_addr];
   assign ld_dur   = ld_entry[DUR_W-1:0];

   assign busy_o  = (state_q != IDLE);
   assign tick    = busy_o && (presc_q == PW'(TICK_DIV - 1));
   assign expire  = tick && (cnt_q == CW'(1));
   assign advance = expire && ((state_q == GAP) || ((state_q == PLAY) && (GAP_TICKS == 0)));
   assign to_gap  = expire && (state_q == PLAY) && (GAP_TICKS != 0);
   assign last    = ({1'b0, idx_q} >= (len_q - (AW+1)'(1)));

   // Which entry (if any) gets loaded this cycle; stop beats start beats advance.
   always_comb begin
      load    = 1'b0;
      finish  = 1'b0;
      ld_addr = '0;
      if (advance) begin
         if (!last) begin
            load    = 1'b1;
            ld_addr = idx_q + AW'(1);
         end else if (loop_i) begin
            load = 1'b1;
         end else begin
            finish = 1'b1;
         end
      end
      if (start_i) begin
         load    = (length_i != '0);
         finish  = (length_i == '0);
         ld_addr = '0;
      end
      if (stop_i) begin
         load   = 1'b0;
         finish = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      cur_note_d = cur_note_q;
      done_d     = 1'b0;
      presc_d    = tick ? '0 : presc_q + PW'(1);
      if (tick && !expire) cnt_d = cnt_q - CW'(1);
      if (to_gap) begin
         state_d = GAP;
         cnt_d   = CW'(GAP_TICKS);
         presc_d = '0;
      end
      if (finish) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end
      if (stop_i) state_d = IDLE;
      if (start_i && !stop_i && (length_i != '0)) begin
         len_d = (length_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length_i;
      end
      if (load) begin
         state_d    = PLAY;
         idx_d      = ld_addr;
         cnt_d      = (ld_dur == '0) ? CW'(1) : CW'(ld_dur);
         cur_note_d = ld_entry[2+DUR_W:DUR_W];
         presc_d    = '0;
      end
      if (state_d == IDLE) presc_d = '0;
      note_d = (key_note_i != 3'd0) ? key_note_i
             : ((state_d == PLAY) ? cur_note_d : 3'd0);
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         len_q      <= '0;
         cur_note_q <= '0;
         note_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         cur_note_q <= cur_note_d;
         note_q     <= note_d;
         done_q     <= done_d;
      end
   end

   assign note_o     = note_q;
   assign step_idx_o = idx_q;
   assign done_o     = done_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed runs push the expected per-cycle output
// trace {note, busy, done, idx}; a monitor pops and compares every cycle.
module tb_note_sequencer;
   localparam int W = 9;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [2:0] wr_note = '0;
   logic [7:0] wr_dur = '0;
   logic [4:0] length = '0;
   logic       loop = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [2:0] key_note = '0;
   logic [2:0] note;
   logic       busy;
   logic [3:0] step_idx;
   logic       done;
   logic [1:0] dbg_state;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v, act_v;
   int           checks = 0;
   int           errors = 0;
   string        tname = "reset";

   note_sequencer #(
      .DEPTH(16), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(1)
   ) dut (
      .clk_i(clk), .resetn_i(resetn), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_note_i(wr_note), .wr_dur_i(wr_dur), .length_i(length), .loop_i(loop),
      .start_i(start), .stop_i(stop), .key_note_i(key_note), .note_o(note),
      .busy_o(busy), .step_idx_o(step_idx), .done_o(done), .state_o(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d trace entries pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act_v = {note, busy, done, step_idx};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s trace @%0t: got note=%0d busy=%0d done=%0d idx=%0d, expected note=%0d busy=%0d done=%0d idx=%0d",
                     tname, $time, act_v[8:6], act_v[5], act_v[4], act_v[3:0],
                     exp_v[8:6], exp_v[5], exp_v[4], exp_v[3:0]);
         end
      end
   end

   // driver tasks (all start and end at posedge + 1)
   task automatic push_seg(input logic [2:0] n, input logic b, input logic d,
                           input logic [3:0] i, input int cnt);
      for (int k = 0; k < cnt; k++) exp_q.push_back({n, b, d, i});
   endtask

   task automatic push_ab();
      push_seg(3'd1, 1'b1, 1'b0, 4'd0, 8);
      push_seg(3'd0, 1'b1, 1'b0, 4'd0, 4);
      push_seg(3'd3, 1'b1, 1'b0, 4'd1, 12);
      push_seg(3'd0, 1'b1, 1'b0, 4'd1, 4);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int a, input logic [2:0] n, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a[3:0];
      wr_note = n;
      wr_dur  = d;
      wait_cyc(1);
      wr_en   = 1'b0;
   endtask

   task automatic start_run(input logic [4:0] len, input logic lp);
      length = len;
      loop   = lp;
      start  = 1'b1;
      wait_cyc(1);
      start  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL %s drain: %0d entries left, expected 0", tname, exp_q.size());
         exp_q.delete();
      end
      #1;
   endtask

   initial begin : stim
      logic [2:0] t_note [16];
      logic [7:0] t_dur [16];
      int         ticks;

      wait_cyc(3);
      resetn = 1'b1;
      push_seg(3'd0, 1'b0, 1'b0, 4'd0, 3);
      drain();

      write_entry(0, 3'd1, 8'd2);
      write_entry(1, 3'd3, 8'd3);

      tname = "single_pass";
      start_run(5'd2, 1'b0);
      push_ab();
      push_seg(3'd0, 1'b0, 1'b1, 4'd1, 1);
      push_seg(3'd0, 1'b0, 1'b0, 4'd1, 2);
      drain();

      tname = "loop";
      start_run(5'd2, 1'b1);
      push_ab();
      push_ab();
      push_seg(3'd0, 1'b0, 1'b1, 4'd1, 1);
      push_seg(3'd0, 1'b0, 1'b0, 4'd1, 2);
      wait_cyc(44);
      loop = 1'b0;
      drain();

      tname = "key_override";
      start_run(5'd2, 1'b0);
      push_seg(3'd1, 1'b1, 1'b0, 4'd0, 2);
      push_seg(3'd5, 1'b1, 1'b0, 4'd0, 3);
      push_seg(3'd1, 1'b1, 1'b0, 4'd0, 3);
      push_seg(3'd0, 1'b1, 1'b0, 4'd0, 4);
      push_seg(3'd3, 1'b1, 1'b0, 4'd1, 12);
      push_seg(3'd0, 1'b1, 1'b0, 4'd1, 4);
      push_seg(3'd0, 1'b0, 1'b1, 4'd1, 1);
      push_seg(3'd0, 1'b0, 1'b0, 4'd1, 2);
      wait_cyc(1);
      key_note = 3'd5;
      wait_cyc(3);
      key_note = 3'd0;
      drain();

      tname = "zero_length";
      start_run(5'd0, 1'b0);
      push_seg(3'd0, 1'b0, 1'b1, 4'd1, 1);
      push_seg(3'd0, 1'b0, 1'b0, 4'd1, 3);
      drain();

      tname = "stop";
      start_run(5'd2, 1'b0);
      push_seg(3'd1, 1'b1, 1'b0, 4'd0, 5);
      wait_cyc(4);
      stop = 1'b1;
      push_seg(3'd0, 1'b0, 1'b0, 4'd0, 6);
      wait_cyc(1);
      stop = 1'b0;
      drain();

      tname = "full_table";
      for (int i = 0; i < 16; i++) begin
         t_note[i] = (i == 0) ? 3'd7 : 3'(i % 8);
         t_dur[i]  = (i == 15) ? 8'd2 : ((i % 4 == 0) ? 8'd0 : 8'd1);
         write_entry(i, t_note[i], t_dur[i]);
      end
      start_run(5'd20, 1'b0);
      for (int i = 0; i < 16; i++) begin
         ticks = (t_dur[i] == 8'd0) ? 1 : int'(t_dur[i]);
         push_seg(t_note[i], 1'b1, 1'b0, 4'(i), 4 * ticks);
         push_seg(3'd0, 1'b1, 1'b0, 4'(i), 4);
      end
      push_seg(3'd0, 1'b0, 1'b1, 4'd15, 1);
      push_seg(3'd0, 1'b0, 1'b0, 4'd15, 2);
      drain();

      tname = "reset_mid_play";
      start_run(5'd2, 1'b0);
      push_seg(3'd7, 1'b1, 1'b0, 4'd0, 1);
      wait_cyc(1);
      resetn = 1'b0;
      push_seg(3'd0, 1'b0, 1'b0, 4'd0, 6);
      wait_cyc(1);
      resetn = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
